// File: rtl/ifu.sv
`timescale 1ns/1ps
// ifu: instruction fetch unit. Owns the fetch PC, issues word reads to
// instruction memory, buffers returned words in an in-order queue and hands
// them to the decoder. Redirects flush everything in flight and buffered.
//
// Handshakes: a transfer happens on a rising edge where valid && ready are
// both high; valid may be withdrawn only by a redirect, and request fields
// hold while valid && !ready. Responses have no backpressure.
module ifu #(
    parameter logic [31:0] RESET_PC = 32'h8000_0000,
    parameter int          DEPTH    = 2
) (
    input  logic        clk,
    input  logic        rst_n,
    output logic        imem_req_valid,
    input  logic        imem_req_ready,
    output logic [31:0] imem_req_addr,
    input  logic        imem_rsp_valid,
    input  logic [31:0] imem_rsp_data,
    input  logic        imem_rsp_err,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_pc,
    output logic        instr_valid,
    input  logic        instr_ready,
    output logic [31:0] instr,
    output logic [31:0] instr_pc,
    output logic        instr_fault,
    output logic [1:0]  dbg_state
);

    localparam int          PW      = $clog2(DEPTH);
    localparam int          CW      = PW + 1;
    localparam logic [CW:0] DEPTH_W = (CW + 1)'(DEPTH);
    localparam logic [31:0] NOP     = 32'h0000_0013;

    typedef enum logic [1:0] {
        ST_BOOT = 2'd0,
        ST_RUN  = 2'd1,
        ST_HALT = 2'd2
    } state_t;

    typedef struct packed {
        logic        fault;
        logic [31:0] pc;
        logic [31:0] word;
    } entry_t;

    state_t        r_state;
    logic [31:0]   r_fetch_pc;
    logic [31:0]   r_rsp_pc;
    logic [CW-1:0] r_inflight;
    logic [CW-1:0] r_drop;
    logic [CW-1:0] r_count;
    logic [PW-1:0] r_wr_ptr;
    logic [PW-1:0] r_rd_ptr;
    entry_t        r_mem [DEPTH];

    logic          w_credit;
    logic          w_fire;
    logic          w_accept;
    logic          w_misalign;
    logic          w_pop;
    logic [CW-1:0] w_inflight_nxt;
    logic          w_wr_en;
    logic [PW-1:0] w_wr_idx;
    entry_t        w_wr_data;
    entry_t        w_head;

    // Credit counts both in-flight requests and buffered words, so every
    // response always has a queue slot waiting for it.
    assign w_credit       = ({1'b0, r_inflight} + {1'b0, r_count}) < DEPTH_W;
    assign imem_req_valid = (r_state == ST_RUN) && !redirect_valid && w_credit;
    assign imem_req_addr  = r_fetch_pc;
    assign w_fire         = imem_req_valid && imem_req_ready;
    assign w_inflight_nxt = r_inflight + CW'(w_fire) - CW'(imem_rsp_valid);
    assign w_accept       = imem_rsp_valid && !redirect_valid && (r_drop == '0);
    assign w_misalign     = redirect_valid && (redirect_pc[1:0] != 2'b00);

    assign instr_valid = (r_count != '0) && !redirect_valid;
    assign w_pop       = instr_valid && instr_ready;
    assign w_head      = r_mem[r_rd_ptr];
    assign instr       = (r_count != '0) ? w_head.word  : 32'h0;
    assign instr_pc    = (r_count != '0) ? w_head.pc    : 32'h0;
    assign instr_fault = (r_count != '0) ? w_head.fault : 1'b0;
    assign dbg_state   = r_state;

    // A misaligned redirect writes its fault marker into slot 0 of the
    // freshly flushed queue; otherwise accepted responses go to the tail.
    assign w_wr_en  = w_misalign || w_accept;
    assign w_wr_idx = w_misalign ? '0 : r_wr_ptr;
    always_comb begin
        w_wr_data = '0;
        if (w_misalign) begin
            w_wr_data = '{fault: 1'b1, pc: redirect_pc, word: NOP};
        end else begin
            w_wr_data = '{fault: imem_rsp_err, pc: r_rsp_pc,
                          word: imem_rsp_err ? NOP : imem_rsp_data};
        end
    end

    // Queue storage: data only, validity is tracked by the pointers.
    always_ff @(posedge clk) begin
        if (w_wr_en) begin
            r_mem[w_wr_idx] <= w_wr_data;
        end
    end

    // Control state: FSM, PCs, in-flight/drop bookkeeping and queue pointers.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state    <= ST_BOOT;
            r_fetch_pc <= RESET_PC;
            r_rsp_pc   <= RESET_PC;
            r_inflight <= '0;
            r_drop     <= '0;
            r_count    <= '0;
            r_wr_ptr   <= '0;
            r_rd_ptr   <= '0;
        end else begin
            r_inflight <= w_inflight_nxt;
            if (redirect_valid) begin
                // Everything still in flight is stale, including any beat
                // arriving this very cycle (already excluded by the decrement).
                r_drop     <= w_inflight_nxt;
                r_fetch_pc <= redirect_pc;
                r_rsp_pc   <= redirect_pc;
                r_rd_ptr   <= '0;
                if (w_misalign) begin
                    r_wr_ptr <= PW'(1);
                    r_count  <= CW'(1);
                    r_state  <= ST_HALT;
                end else begin
                    r_wr_ptr <= '0;
                    r_count  <= '0;
                    r_state  <= ST_RUN;
                end
            end else begin
                if (w_fire) begin
                    r_fetch_pc <= r_fetch_pc + 32'd4;
                end
                if (imem_rsp_valid && (r_drop != '0)) begin
                    r_drop <= r_drop - CW'(1);
                end else if (w_accept && imem_rsp_err) begin
                    r_drop <= w_inflight_nxt;
                end
                if (w_accept) begin
                    r_rsp_pc <= r_rsp_pc + 32'd4;
                    r_wr_ptr <= r_wr_ptr + PW'(1);
                end
                if (w_pop) begin
                    r_rd_ptr <= r_rd_ptr + PW'(1);
                end
                r_count <= r_count + CW'(w_accept) - CW'(w_pop);
                case (r_state)
                    ST_BOOT: r_state <= ST_RUN;
                    ST_RUN:  if (w_accept && imem_rsp_err) r_state <= ST_HALT;
                    default: r_state <= ST_HALT;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_ifu.sv
`timescale 1ns/1ps
// Bench for ifu: an in-order instruction memory model with adjustable
// latency and fault injection, a scoreboard queue of expected decoder-side
// entries, and directed scenarios with hand-computed PCs.
module tb_ifu;

  localparam int          DEPTH = 4;
  localparam logic [31:0] RPC   = 32'h8000_0000;
  localparam logic [31:0] NOP   = 32'h0000_0013;
  localparam logic [31:0] NO_ERR = 32'hFFFF_FFFF;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic        imem_req_valid, imem_req_ready;
  logic [31:0] imem_req_addr;
  logic        imem_rsp_valid, imem_rsp_err;
  logic [31:0] imem_rsp_data;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        instr_valid, instr_ready, instr_fault;
  logic [31:0] instr, instr_pc;
  logic [1:0]  dbg_state;

  ifu #(.RESET_PC(RPC), .DEPTH(DEPTH)) dut (
    .clk(clk), .rst_n(rst_n),
    .imem_req_valid(imem_req_valid), .imem_req_ready(imem_req_ready),
    .imem_req_addr(imem_req_addr),
    .imem_rsp_valid(imem_rsp_valid), .imem_rsp_data(imem_rsp_data),
    .imem_rsp_err(imem_rsp_err),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
    .instr_valid(instr_valid), .instr_ready(instr_ready),
    .instr(instr), .instr_pc(instr_pc), .instr_fault(instr_fault),
    .dbg_state(dbg_state)
  );

  int n_vec = 0;
  int n_err = 0;
  int n_fire = 0;
  int n_pop = 0;
  int max_out = 0;
  int cyc = 0;
  int mem_lat = 1;
  logic [31:0] err_addr = NO_ERR;

  logic [64:0] exp_q[$];
  logic [31:0] pend_addr[$];
  int          pend_due[$];

  function automatic logic [31:0] word_at(input logic [31:0] a);
    return ~a;
  endfunction

  // ---------------- driver tasks ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
    n_vec++;
    if (act !== req) begin
      n_err++;
      $display("FAIL %s: got %h, expected %h", nm, act, req);
    end
  endtask

  task automatic expect_ok(input logic [31:0] pc);
    exp_q.push_back({1'b0, pc, word_at(pc)});
  endtask

  task automatic expect_fault(input logic [31:0] pc);
    exp_q.push_back({1'b1, pc, NOP});
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    instr_ready = 1'b0;
    redirect_valid = 1'b0;
    redirect_pc = 32'h0;
    imem_req_ready = 1'b1;
    mem_lat = 1;
    err_addr = NO_ERR;
    tick();
    tick();
    exp_q.delete();
    n_fire = 0;
    n_pop = 0;
    max_out = 0;
    rst_n = 1'b1;
    #1;
  endtask

  task automatic chk_reset_outs(input string tag);
    chk({tag, "_req_valid"},   {31'h0, imem_req_valid}, 32'h0);
    chk({tag, "_req_addr"},    imem_req_addr, RPC);
    chk({tag, "_instr_valid"}, {31'h0, instr_valid}, 32'h0);
    chk({tag, "_instr"},       instr, 32'h0);
    chk({tag, "_instr_pc"},    instr_pc, 32'h0);
    chk({tag, "_instr_fault"}, {31'h0, instr_fault}, 32'h0);
    chk({tag, "_state"},       {30'h0, dbg_state}, 32'h0);
  endtask

  task automatic wait_drain(input string nm, input int budget);
    for (int i = 0; i < budget && exp_q.size() != 0; i++) tick();
    n_vec++;
    if (exp_q.size() != 0) begin
      n_err++;
      $display("FAIL %s_drain: %0d entries still expected, required 0", nm, exp_q.size());
    end
  endtask

  task automatic redirect_to(input logic [31:0] pc);
    redirect_valid = 1'b1;
    redirect_pc = pc;
    tick();
    redirect_valid = 1'b0;
    #1;
  endtask

  // ---------------- memory model ----------------
  initial begin
    imem_rsp_valid = 1'b0;
    imem_rsp_data = 32'h0;
    imem_rsp_err = 1'b0;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        pend_addr.delete();
        pend_due.delete();
      end else if (imem_req_valid && imem_req_ready) begin
        pend_addr.push_back(imem_req_addr);
        pend_due.push_back(cyc + mem_lat);
        n_fire++;
      end
      @(posedge clk);
      cyc++;
      #1;
      imem_rsp_valid = 1'b0;
      imem_rsp_data = 32'h0;
      imem_rsp_err = 1'b0;
      if (pend_addr.size() > 0 && pend_due[0] <= cyc) begin
        logic [31:0] a;
        a = pend_addr.pop_front();
        void'(pend_due.pop_front());
        imem_rsp_valid = 1'b1;
        imem_rsp_data = word_at(a);
        imem_rsp_err = (a == err_addr);
      end
    end
  end

  // ---------------- scoreboard monitor ----------------
  always @(negedge clk) begin
    if (instr_valid && instr_ready) begin
      n_pop++;
      n_vec++;
      if (exp_q.size() == 0) begin
        n_err++;
        $display("FAIL pop_unexpected: got pc=%h instr=%h fault=%b, expected no entry",
                 instr_pc, instr, instr_fault);
      end else begin
        logic [64:0] e;
        e = exp_q.pop_front();
        if ({instr_fault, instr_pc, instr} !== e) begin
          n_err++;
          $display("FAIL pop_entry: got fault=%b pc=%h instr=%h, expected fault=%b pc=%h instr=%h",
                   instr_fault, instr_pc, instr, e[64], e[63:32], e[31:0]);
        end
      end
    end
  end

  always @(posedge clk) begin
    if (n_fire - n_pop > max_out) max_out = n_fire - n_pop;
  end

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------- directed scenarios ----------------
  initial begin
    int f0;

    // S1: reset state, boot timing, in-order 1/cycle delivery
    do_reset();
    chk_reset_outs("s1_boot");
    instr_ready = 1'b1;
    for (int i = 0; i < 8; i++) expect_ok(RPC + 32'(4 * i));
    tick();
    chk("s1_first_req_valid", {31'h0, imem_req_valid}, 32'h1);
    chk("s1_first_req_addr", imem_req_addr, 32'h8000_0000);
    tick();
    chk("s1_second_req_addr", imem_req_addr, 32'h8000_0004);
    chk("s1_valid_early", {31'h0, instr_valid}, 32'h0);
    tick();
    chk("s1_first_valid", {31'h0, instr_valid}, 32'h1);
    chk("s1_first_pc", instr_pc, 32'h8000_0000);
    repeat (8) tick();
    chk("s1_rate", exp_q.size(), 32'h0);
    instr_ready = 1'b0;

    // S2: decoder stalled, credit bound, no loss on release
    do_reset();
    repeat (12) tick();
    chk("s2_max_outstanding", max_out, DEPTH);
    chk("s2_fires", n_fire, DEPTH);
    for (int i = 0; i < 8; i++) expect_ok(RPC + 32'(4 * i));
    instr_ready = 1'b1;
    wait_drain("s2", 60);
    instr_ready = 1'b0;

    // S3: aligned redirect with two in flight and one queued
    do_reset();
    mem_lat = 3;
    repeat (4) tick();
    imem_req_ready = 1'b0;
    chk("s3_fires", n_fire, 3);
    tick();
    chk("s3_queued", {31'h0, instr_valid}, 32'h1);
    redirect_valid = 1'b1;
    redirect_pc = 32'h8000_0100;
    #1;
    chk("s3_redir_instr_valid", {31'h0, instr_valid}, 32'h0);
    chk("s3_redir_req_valid", {31'h0, imem_req_valid}, 32'h0);
    mem_lat = 1;
    imem_req_ready = 1'b1;
    instr_ready = 1'b1;
    for (int i = 0; i < 4; i++) expect_ok(32'h8000_0100 + 32'(4 * i));
    tick();
    redirect_valid = 1'b0;
    #1;
    chk("s3_target_req_valid", {31'h0, imem_req_valid}, 32'h1);
    chk("s3_target_req_addr", imem_req_addr, 32'h8000_0100);
    tick();
    chk("s3_valid_n2", {31'h0, instr_valid}, 32'h0);
    tick();
    chk("s3_valid_n3", {31'h0, instr_valid}, 32'h1);
    chk("s3_pc_n3", instr_pc, 32'h8000_0100);
    wait_drain("s3", 40);
    instr_ready = 1'b0;

    // S4: misaligned redirect yields one fault entry and halts fetch
    do_reset();
    repeat (5) tick();
    expect_fault(32'h8000_0102);
    redirect_to(32'h8000_0102);
    chk("s4_fault_valid", {31'h0, instr_valid}, 32'h1);
    chk("s4_fault_flag", {31'h0, instr_fault}, 32'h1);
    chk("s4_fault_pc", instr_pc, 32'h8000_0102);
    chk("s4_fault_instr", instr, NOP);
    f0 = n_fire;
    instr_ready = 1'b1;
    repeat (15) tick();
    chk("s4_no_fetch", n_fire - f0, 0);
    chk("s4_halt_state", {30'h0, dbg_state}, 32'h2);
    chk("s4_queue_empty", {31'h0, instr_valid}, 32'h0);
    for (int i = 0; i < 3; i++) expect_ok(RPC + 32'(4 * i));
    redirect_to(32'h8000_0000);
    wait_drain("s4", 40);
    instr_ready = 1'b0;

    // S5: access fault on 0x80000008, later beat dropped, HALT, resume
    do_reset();
    err_addr = 32'h8000_0008;
    instr_ready = 1'b1;
    expect_ok(32'h8000_0000);
    expect_ok(32'h8000_0004);
    expect_fault(32'h8000_0008);
    wait_drain("s5", 40);
    f0 = n_fire;
    repeat (10) tick();
    chk("s5_no_fetch", n_fire - f0, 0);
    chk("s5_halt_state", {30'h0, dbg_state}, 32'h2);
    err_addr = NO_ERR;
    for (int i = 0; i < 3; i++) expect_ok(RPC + 32'(4 * i));
    redirect_to(32'h8000_0000);
    wait_drain("s5_resume", 40);
    instr_ready = 1'b0;

    // S6: redirect colliding with a response and a would-be pop, then reset
    do_reset();
    instr_ready = 1'b1;
    repeat (3) tick();
    chk("s6_pre_valid", {31'h0, instr_valid}, 32'h1);
    redirect_valid = 1'b1;
    redirect_pc = 32'h8000_0200;
    #1;
    chk("s6_redir_instr_valid", {31'h0, instr_valid}, 32'h0);
    chk("s6_redir_req_valid", {31'h0, imem_req_valid}, 32'h0);
    for (int i = 0; i < 3; i++) expect_ok(32'h8000_0200 + 32'(4 * i));
    tick();
    redirect_valid = 1'b0;
    wait_drain("s6", 40);
    instr_ready = 1'b0;
    repeat (3) tick();
    rst_n = 1'b0;
    tick();
    chk_reset_outs("s6_midreset");
    exp_q.delete();
    rst_n = 1'b1;
    expect_ok(32'h8000_0000);
    expect_ok(32'h8000_0004);
    instr_ready = 1'b1;
    wait_drain("s6_after_reset", 40);
    instr_ready = 1'b0;
    repeat (3) tick();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/ifu.md
# ifu

Instruction fetch unit for the single-issue RV32 core. It owns the fetch PC, issues word reads to instruction memory over a request/response interface, and buffers returned words in a small in-order queue. It presents them to the decoder over a valid/ready handshake. Branch/jump/trap redirects flush all in-flight and buffered fetches.

## Interface
- `RESET_PC`, default `32'h8000_0000`: fetch PC after reset.
- `DEPTH`, default `2`: queue entries and maximum in-flight plus buffered words. Must be a power of 2, at least 2.

Ports:
- `clk` in 1: single clock, rising edge.
- `rst_n` in 1: synchronous, active-low reset.
- `imem_req_valid` out 1: fetch request.
- `imem_req_ready` in 1: memory accepts the request.
- `imem_req_addr` out 32: word-aligned fetch address.
- `imem_rsp_valid` in 1: response beat. Responses are in order and return at least 1 cycle after their request fires. There is no backpressure on responses.
- `imem_rsp_data` in 32: instruction word.
- `imem_rsp_err` in 1: access fault for this beat.
- `redirect_valid` in 1: new PC from EXU/trap logic.
- `redirect_pc` in 32: redirect target.
- `instr_valid` out 1: decoder-side valid.
- `instr_ready` in 1: decoder accepts.
- `instr` out 32: instruction word.
- `instr_pc` out 32: PC of `instr`.
- `instr_fault` out 1: entry is a fault marker (`instr` = `32'h0000_0013`).

## Operation
FSM has three states: BOOT, RUN, HALT.
- BOOT: entered by reset; lasts exactly 1 cycle, then goes to RUN. No requests are issued.
- RUN: issues requests when a credit is available.
- HALT: no requests are issued. Leaves only on `redirect_valid`: to RUN if the target is aligned, otherwise stays in HALT.

Counters and credit:
- `inflight`: increments on request fire (`imem_req_valid && imem_req_ready`), decrements on `imem_rsp_valid`. Both in the same cycle means no change.
- `drop`: count of in-flight responses to discard. Always ≤ `inflight`.
- Credit rule: `imem_req_valid` = RUN && !`redirect_valid` && (`inflight` + `count`) < `DEPTH`.
- The queue therefore never overflows.

Fetch PC:
- `imem_req_addr` = `fetch_pc`.
- On fire: `fetch_pc` += 4, modulo 2^32 (`32'hFFFF_FFFC` wraps to 0).

Responses:
- If `drop` > 0 or `redirect_valid`: discard the response; `drop` decrements if it was nonzero.
- Else push {`imem_rsp_data`, `pc`, `fault` = `imem_rsp_err`}. Push PC is tracked by a `rsp_pc` register that advances by 4 per accepted response.
- On err: push the entry with `instr` replaced by `32'h0000_0013`, go to HALT, and set `drop` = remaining `inflight` after this cycle.

Redirect (highest priority, beats every other same-cycle event):
- Queue is cleared.
- `drop` ← `inflight` after this cycle's decrement. This cycle's response is itself discarded.
- `fetch_pc` and `rsp_pc` ← `redirect_pc`.
- If `redirect_pc[1:0]` ≠ 0: push a single fault entry (`instr` = `32'h0000_0013`, `instr_pc` = `redirect_pc`, fault = 1) and go to HALT.
- Otherwise go to RUN. A redirect during BOOT applies and the FSM proceeds to RUN.

Decoder side:
- `instr_valid` = (`count` ≠ 0) && !`redirect_valid`.
- Pop on `instr_valid && instr_ready`.
- Push and pop in the same cycle are both honoured, and `count` is unchanged.

Reset (`rst_n` = 0 at an edge, even mid-transaction):
- State → BOOT, `fetch_pc` = `rsp_pc` = `RESET_PC`, `inflight` = `drop` = `count` = 0, queue pointers 0.
- All outputs are 0 except `imem_req_addr` = `RESET_PC`.
- Memory-side responses to pre-reset requests are not tracked after reset; the memory is reset together with the IFU.

## Timing
- Reset release at edge E: BOOT during cycle E+1, first `imem_req_valid` in cycle E+2.
- Response accepted in cycle N: `instr_valid` high in N+1 (queue is registered; no response-to-output combinational path).
- Best-case issue-to-decode latency is 2 cycles; sustained throughput is 1 instr/cycle with `DEPTH` ≥ 2 and 1-cycle memory.
- Redirect in cycle N: first request to the target in N+1, earliest target `instr_valid` in N+3.
- Request fields hold stable while `imem_req_valid && !imem_req_ready`, unless a redirect arrives. A redirect withdraws the request, which is permitted.
- `redirect_valid` → `instr_valid` and `redirect_valid` → `imem_req_valid` are the only combinational input-to-output paths.

## Test plan
- Reset release with 1-cycle memory and `instr_ready` = 1: requests to 0x80000000, 0x80000004, …; `instr`/`instr_pc` pairs delivered in order, 1 per cycle, first `instr_valid` 3 cycles after BOOT.
- `instr_ready` held 0 for 10 cycles: at most `DEPTH` requests outstanding plus buffered, none lost. On release, PCs 0x80000000.. arrive without gaps or duplicates.
- Redirect to 0x80000100 with 2 requests in flight and 1 entry queued: both stale responses dropped, queue flushed, next delivered `instr_pc` = 0x80000100.
- Redirect to 0x80000102: one fault entry (`instr_fault` = 1, `instr_pc` = 0x80000102, `instr` = 0x00000013), no requests issued afterwards until an aligned redirect.
- `imem_rsp_err` on the word at 0x80000008: fault entry delivered with `instr_pc` 0x80000008, later in-flight beat dropped, HALT. Redirect to 0x80000000 resumes fetch.
- Redirect coinciding with a response and a decoder pop in the same cycle: the response is discarded and no handshake completes. Also apply `rst_n` low mid-stream: all outputs return to reset values at the next edge.
